// File: rtl/bcd_pulse_gen_pkg.sv
// Shared definitions for the BCD pulse generator: digit limit, FSM states,
// and the phase-counter width helper.
package bcd_pulse_gen_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } state_t;

  // Wide enough to count to the longer of the two phases, with one spare bit.
  function automatic int unsigned phase_width(input int unsigned pulse_w,
                                              input int unsigned gap_cyc);
    int unsigned longest;
    longest = (pulse_w > gap_cyc) ? pulse_w : gap_cyc;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/bcd_pulse_gen_if.sv
// Control/status bundle between the requesting logic and bcd_pulse_gen.
interface bcd_pulse_gen_if #(
  parameter int unsigned NDIG = 2
);

  logic                start;
  logic [4*NDIG-1:0]   value;
  logic                ready;
  logic                busy;
  logic                pulse;
  logic [4*NDIG-1:0]   remaining;
  logic                done;
  logic                err;

  modport master (
    output start, value,
    input  ready, busy, pulse, remaining, done, err
  );

  modport slave (
    input  start, value,
    output ready, busy, pulse, remaining, done, err
  );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD digit of the remaining-count register: loadable, counts down with
// 0 -> 9 wrap and borrow-out into the next digit.
module bcd_digit_down
  import bcd_pulse_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic [3:0] o_digit,
  output logic       o_borrow,
  output logic       o_zero,
  output logic       o_invalid
);

  logic [3:0] r_digit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_dec) begin
      r_digit <= (r_digit == 4'd0) ? BCD_MAX : (r_digit - 4'd1);
    end
  end

  assign o_digit   = r_digit;
  assign o_borrow  = i_dec && (r_digit == 4'd0);
  assign o_zero    = (r_digit == 4'd0);
  // Judges the value being offered for load, not the stored digit.
  assign o_invalid = (i_load_val > BCD_MAX);

endmodule

// File: rtl/bcd_pulse_gen.sv
// Emits exactly decimal(value) pulses of PULSE_W high / GAP_CYC low cycles,
// tracking the outstanding count in a chain of BCD down-counting digits.
module bcd_pulse_gen
  import bcd_pulse_gen_pkg::*;
#(
  parameter int unsigned NDIG    = 2,
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic           clk,
  input  logic           rst,
  bcd_pulse_gen_if.slave bus
);

  localparam int unsigned PH_W = phase_width(PULSE_W, GAP_CYC);
  localparam int unsigned VW   = 4 * NDIG;

  state_t          r_state;
  logic [PH_W-1:0] r_phase;
  logic            r_ready;
  logic            r_busy;
  logic            r_pulse;
  logic            r_done;
  logic            r_err;

  logic [VW-1:0]   w_rem;
  logic [NDIG-1:0] w_dec;
  logic [NDIG-1:0] w_borrow;
  logic [NDIG-1:0] w_zero;
  logic [NDIG-1:0] w_invalid;
  logic            w_any_invalid;
  logic            w_value_zero;
  logic            w_load;
  logic            w_dec_req;
  logic            w_all_zero;
  logic            w_is_one;
  logic            w_hi_last;
  logic            w_lo_last;
  logic            w_train_end;

  assign w_any_invalid = |w_invalid;
  assign w_value_zero  = (bus.value == '0);
  assign w_all_zero    = &w_zero;
  assign w_is_one      = (w_rem == VW'(1));
  assign w_hi_last     = (r_phase == PH_W'(PULSE_W - 1));
  assign w_lo_last     = (r_phase == PH_W'(GAP_CYC - 1));

  assign w_load    = (r_state == ST_IDLE) && bus.start && !w_any_invalid && !w_value_zero;
  assign w_dec_req = (r_state == ST_HIGH) && w_hi_last && !w_all_zero;
  // Count reaches zero on this decrement; underflow/zero terms are purely defensive.
  assign w_train_end = w_is_one || w_all_zero || w_borrow[NDIG-1];

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    if (g == 0) begin : g_lsd
      assign w_dec[g] = w_dec_req;
    end else begin : g_upper
      assign w_dec[g] = w_borrow[g-1];
    end

    bcd_digit_down u_digit (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (bus.value[4*g +: 4]),
      .i_dec      (w_dec[g]),
      .o_digit    (w_rem[4*g +: 4]),
      .o_borrow   (w_borrow[g]),
      .o_zero     (w_zero[g]),
      .o_invalid  (w_invalid[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (w_any_invalid) begin
              r_err <= 1'b1;
            end else if (w_value_zero) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_HIGH;
              r_phase <= '0;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_pulse <= 1'b1;
            end
          end
        end
        ST_HIGH: begin
          if (w_hi_last) begin
            r_phase <= '0;
            r_pulse <= 1'b0;
            if (w_train_end) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_state <= ST_LOW;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        ST_LOW: begin
          if (w_lo_last) begin
            r_phase <= '0;
            r_pulse <= 1'b1;
            r_state <= ST_HIGH;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = r_ready;
  assign bus.busy      = r_busy;
  assign bus.pulse     = r_pulse;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.remaining = w_rem;

endmodule
